alu_bcd_display: RTL and testbench
==================================

# alu_bcd_display

Two-digit multiplexed seven-segment display driver that consumes the ALU result: tens/units BCD digits plus zero and error flags. Sits downstream of the ALU on the result path. Captures a result on a load strobe and time-multiplexes the two digits onto a shared segment bus. Handles leading-zero blanking, an "Er" error pattern, and detection of invalid BCD digits.

## Interface
Parameters:
- REFRESH_DIV, default 1000: clock cycles each digit stays enabled. Legal range is ≥ 2; values below 2 are a configuration error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- load  in  1  one-cycle strobe that captures dec_in, unis_in, zero_in, error_in
- dec_in  in  4  tens digit (BCD)
- unis_in  in  4  units digit (BCD)
- zero_in  in  1  result-is-zero flag
- error_in  in  1  ALU error flag
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high
- dig_en  out  2  digit enable, one-hot or 00; bit1 = tens, bit0 = units
- loaded  out  1  one-cycle acknowledge of a capture
- bcd_fault  out  1  sticky flag: a captured digit was > 9 while error_in = 0

## Operation
- **States:** BLANK, SHOW_UNITS, SHOW_TENS.
- **Reset:**
  - State BLANK, all captured registers cleared to 0, refresh counter 0.
  - Outputs: seg = 0, dig_en = 00, loaded = 0, bcd_fault = 0.
- **BLANK:** outputs held at 0. A load moves the state to SHOW_UNITS and clears the counter.
- **Refresh:** in SHOW_*, the counter runs 0..REFRESH_DIV-1. On wrap, SHOW_UNITS switches to SHOW_TENS and SHOW_TENS switches to SHOW_UNITS. The state never returns to BLANK except through reset.
- **Display mode** is decided from the captured values, in this priority order:
  - cap_error = 1: tens shows "E" (0x79), units shows "r" (0x50).
  - Either captured digit > 9: shown as "Er", and bcd_fault is set.
  - Otherwise: units shows the decoded digit. Tens shows the decoded digit when cap_dec ≠ 0; when cap_dec = 0 the tens digit is blank (seg = 0x00, dig_en still 10).
- **zero_in:** captured and used only as a consistency check. zero_in = 1 with digits ≠ 00 (and error_in = 0) sets bcd_fault.
- **Segment codes, 0–9:** 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).
- **bcd_fault:** sticky. Cleared only by reset.
- **load while in SHOW_*:** values are recaptured. The state and counter are NOT disturbed, and the new data appears on the currently active digit.
- **Back-to-back loads:** each one is captured and each one pulses loaded. The last load wins.

## Timing
- load sampled high at edge N:
  - Capture registers update at edge N.
  - loaded is high for the cycle following edge N.
  - seg and dig_en reflect the new data from edge N+1; all outputs are registered.
- First load from BLANK: dig_en = 01 from edge N+1 for REFRESH_DIV cycles, then 10 for REFRESH_DIV cycles, and so on.
- dig_en and seg change on the same edge; there is no cycle with a mismatched digit/segment pair.
- load coincident with a counter wrap: the digit switches as normal, and the new data is shown on the new digit at the next edge.
- Reset asserted mid-display: outputs go to 0 immediately, without waiting for a clock edge.

## Structure
- Package alu_disp_pkg holds:
  - The state enum (BLANK, SHOW_UNITS, SHOW_TENS).
  - Segment constants SEG_0..SEG_9, SEG_E, SEG_R, SEG_BLANK.
- Sub-module bcd_to_seg: combinational, maps 4-bit value to 7-bit seg, returning SEG_BLANK for values > 9.
- Top level holds the capture registers, FSM, refresh counter, mode mux and fault logic.

## Test plan
Run with REFRESH_DIV = 4.
- **Reset then idle:** outputs seg = 0, dig_en = 00, loaded = 0 for 20 cycles.
- **Load dec = 4, unis = 2:**
  - loaded pulses once.
  - Next: dig_en = 01 with seg = 0x5B for 4 cycles.
  - Then: dig_en = 10 with seg = 0x66 for 4 cycles, repeating.
- **Load dec = 0, unis = 7:**
  - Units phase: seg = 0x07.
  - Tens phase: dig_en = 10 with seg = 0x00.
  - bcd_fault stays 0.
- **Load error_in = 1 (digits 15/15):**
  - Units phase seg = 0x50, tens phase seg = 0x79.
  - bcd_fault stays 0.
- **Load dec = 0, unis = 12, error_in = 0:**
  - Display shows "Er" and bcd_fault = 1.
  - A following valid load (1/3) shows 0x4F/0x06 while bcd_fault remains 1.
- **Mid-operation events:**
  - Load during the 2nd cycle of the units phase: the phase still lasts 4 cycles total, with the new digit visible from the next edge.
  - Async reset pulsed mid-phase: outputs go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/alu_disp_pkg.sv
// Shared types and seven-segment codes for the two-digit ALU result display.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package alu_disp_pkg;

    typedef enum logic [1:0] {
        BLANK      = 2'd0,
        SHOW_UNITS = 2'd1,
        SHOW_TENS  = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/alu_bcd_display_bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; non-decimal codes come out blank.
module bcd_to_seg
    import alu_disp_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/alu_bcd_display.sv
// Two-digit multiplexed seven-segment driver for the ALU result: captures on load,
// alternates units/tens every REFRESH_DIV cycles, shows "Er" on error or bad BCD.
module alu_bcd_display
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] dec_in,
    input  logic [3:0] unis_in,
    input  logic       zero_in,
    input  logic       error_in,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       loaded,
    output logic       bcd_fault
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    generate
        if (REFRESH_DIV < 2) begin : g_bad_cfg
            $error("alu_bcd_display: REFRESH_DIV must be at least 2");
        end
    endgenerate

    disp_state_t   state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    cap_dec_reg, cap_unis_reg;
    logic          cap_zero_reg, cap_error_reg;
    logic [6:0]    seg_next;
    logic [1:0]    dig_en_next;
    logic          show_er, fault_now;

    logic [3:0] digit_val [2];
    logic [6:0] digit_seg [2];

    assign digit_val[0] = cap_unis_reg;
    assign digit_val[1] = cap_dec_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dec
            bcd_to_seg u_bcd_to_seg (
                .value (digit_val[gi]),
                .seg   (digit_seg[gi])
            );
        end
    endgenerate

    assign show_er   = cap_error_reg || (cap_dec_reg > 4'd9) || (cap_unis_reg > 4'd9);
    // Fault is judged on the captured values, so it rises together with the new display.
    assign fault_now = !cap_error_reg &&
                       ((cap_dec_reg > 4'd9) || (cap_unis_reg > 4'd9) ||
                        (cap_zero_reg && ((cap_dec_reg != 4'd0) || (cap_unis_reg != 4'd0))));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            BLANK: begin
                if (load) begin
                    state_next = SHOW_UNITS;
                    cnt_next   = '0;
                end
            end
            SHOW_UNITS, SHOW_TENS: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = (state_reg == SHOW_UNITS) ? SHOW_TENS : SHOW_UNITS;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = BLANK;
                cnt_next   = '0;
            end
        endcase
    end

    // Segment/enable pair is derived from the current state so both register together.
    always_comb begin
        seg_next    = SEG_BLANK;
        dig_en_next = 2'b00;
        case (state_reg)
            SHOW_UNITS: begin
                dig_en_next = 2'b01;
                seg_next    = show_er ? SEG_R : digit_seg[0];
            end
            SHOW_TENS: begin
                dig_en_next = 2'b10;
                if (show_er)
                    seg_next = SEG_E;
                else if (cap_dec_reg == 4'd0)
                    seg_next = SEG_BLANK;
                else
                    seg_next = digit_seg[1];
            end
            default: begin
                seg_next    = SEG_BLANK;
                dig_en_next = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= BLANK;
            cnt_reg       <= '0;
            cap_dec_reg   <= 4'd0;
            cap_unis_reg  <= 4'd0;
            cap_zero_reg  <= 1'b0;
            cap_error_reg <= 1'b0;
            seg           <= SEG_BLANK;
            dig_en        <= 2'b00;
            loaded        <= 1'b0;
            bcd_fault     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            seg       <= seg_next;
            dig_en    <= dig_en_next;
            loaded    <= load;
            bcd_fault <= bcd_fault | (loaded & fault_now);
            if (load) begin
                cap_dec_reg   <= dec_in;
                cap_unis_reg  <= unis_in;
                cap_zero_reg  <= zero_in;
                cap_error_reg <= error_in;
            end
        end
    end

endmodule

// File: tb/tb_alu_bcd_display.sv
// Self-checking bench for alu_bcd_display with a cycle-indexed reference model.
module tb_alu_bcd_display;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] dec_in = 4'd0;
    logic [3:0] unis_in = 4'd0;
    logic       zero_in = 1'b0;
    logic       error_in = 1'b0;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       loaded;
    logic       bcd_fault;

    int total = 0;
    int bad = 0;

    alu_bcd_display #(.REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .dec_in    (dec_in),
        .unis_in   (unis_in),
        .zero_in   (zero_in),
        .error_in  (error_in),
        .seg       (seg),
        .dig_en    (dig_en),
        .loaded    (loaded),
        .bcd_fault (bcd_fault)
    );

    always #5 clk = ~clk;

    // Reference model: display time is measured from the first load edge.
    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int         k = 0;
    bit         started = 0;
    int         first_edge = 0;
    logic [3:0] m_d = 0, m_u = 0;
    logic       m_z = 0, m_e = 0;
    bit         m_fault = 0;
    logic [10:0] exp_vec;
    int         exp_pos;
    bit         exp_tens;

    function automatic logic [6:0] ref_seg(input bit tens);
        if (m_e || m_d > 9 || m_u > 9) return tens ? 7'h79 : 7'h50;
        if (!tens) return seg_tbl[int'(m_u)];
        return (m_d == 0) ? 7'h00 : seg_tbl[int'(m_d)];
    endfunction

    function automatic logic [10:0] observed();
        return {seg, dig_en, loaded, bcd_fault};
    endfunction

    task automatic model_reset();
        started = 0; m_d = 0; m_u = 0; m_z = 0; m_e = 0; m_fault = 0;
    endtask

    task automatic step(input logic ld, input logic [3:0] d, input logic [3:0] u,
                        input logic z, input logic e);
        int t;
        load = ld; dec_in = d; unis_in = u; zero_in = z; error_in = e;
        @(posedge clk);
        k++;
        if (started && first_edge < k) begin
            t        = k - first_edge - 1;
            exp_tens = ((t / RD) % 2) == 1;
            exp_pos  = t % RD;
            exp_vec  = {ref_seg(exp_tens), exp_tens ? 2'b10 : 2'b01, ld, m_fault};
        end else begin
            exp_tens = 0;
            exp_pos  = -1;
            exp_vec  = {7'h00, 2'b00, ld, m_fault};
        end
        if (ld) begin
            $display("load k=%0d dec=%0d unis=%0d zero=%0b err=%0b", k, d, u, z, e);
            m_d = d; m_u = u; m_z = z; m_e = e;
            if (!e && (d > 9 || u > 9 || (z && (d != 0 || u != 0)))) m_fault = 1;
            if (!started) begin
                started    = 1;
                first_edge = k;
            end
        end
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (observed() !== 11'd0) begin
            bad++; $display("FAIL reset_held got=%h want=000", observed());
        end
        @(negedge clk) reset = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0);
            total++;
            if (observed() !== exp_vec) begin
                bad++; $display("FAIL reset_idle k=%0d got=%h want=%h", k, observed(), exp_vec);
            end
        end
    endtask

    task automatic test_load_run(input string name, input logic [3:0] d, input logic [3:0] u,
                                 input logic z, input logic e, input int cycles);
        step(1, d, u, z, e);
        total++;
        if (observed() !== exp_vec) begin
            bad++; $display("FAIL %s k=%0d got=%h want=%h", name, k, observed(), exp_vec);
        end
        for (int i = 0; i < cycles; i++) begin
            step(0, 0, 0, 0, 0);
            total++;
            if (observed() !== exp_vec) begin
                bad++; $display("FAIL %s k=%0d got=%h want=%h", name, k, observed(), exp_vec);
            end
        end
    endtask

    task automatic test_fault_sticky();
        test_load_run("bad_digit", 4'd0, 4'd12, 0, 0, 10);
        total++;
        if (bcd_fault !== 1'b1) begin
            bad++; $display("FAIL bad_digit_flag got=%0b want=1", bcd_fault);
        end
        test_load_run("after_bad", 4'd1, 4'd3, 0, 0, 10);
        total++;
        if (bcd_fault !== 1'b1) begin
            bad++; $display("FAIL fault_sticky got=%0b want=1", bcd_fault);
        end
    endtask

    task automatic test_mid_load();
        int n = 0;
        while (!(exp_pos == 0 && !exp_tens) && n < 20) begin
            step(0, 0, 0, 0, 0);
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++; $display("FAIL mid_load_align timeout got=%0d want=<20", n);
        end
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(i == 0, 4'd8, 4'd5, 0, 0);
            total++;
            if (observed() !== exp_vec) begin
                bad++; $display("FAIL mid_load k=%0d got=%h want=%h", k, observed(), exp_vec);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            step(i < 3, 4'(i + 2), 4'(9 - i), 0, 0);
            total++;
            if (observed() !== exp_vec) begin
                bad++; $display("FAIL back_to_back k=%0d got=%h want=%h", k, observed(), exp_vec);
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (5) step(0, 0, 0, 0, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (observed() !== 11'd0) begin
            bad++; $display("FAIL async_reset got=%h want=000", observed());
        end
        @(negedge clk) reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0);
            total++;
            if (observed() !== exp_vec) begin
                bad++; $display("FAIL after_reset k=%0d got=%h want=%h", k, observed(), exp_vec);
            end
        end
    endtask

    task automatic test_random();
        logic ld, z, e;
        for (int i = 0; i < 200; i++) begin
            ld = ($urandom_range(0, 4) == 0);
            z  = ($urandom_range(0, 3) == 0);
            e  = ($urandom_range(0, 7) == 0);
            step(ld, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), z, e);
            total++;
            if (observed() !== exp_vec) begin
                bad++; $display("FAIL random k=%0d got=%h want=%h", k, observed(), exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_run("load_42", 4'd4, 4'd2, 0, 0, 16);
        test_load_run("load_07", 4'd0, 4'd7, 0, 0, 10);
        total++;
        if (bcd_fault !== 1'b0) begin
            bad++; $display("FAIL blank_tens_fault got=%0b want=0", bcd_fault);
        end
        test_load_run("load_err", 4'd15, 4'd15, 0, 1, 10);
        total++;
        if (bcd_fault !== 1'b0) begin
            bad++; $display("FAIL error_fault got=%0b want=0", bcd_fault);
        end
        test_fault_sticky();
        test_mid_load();
        test_back_to_back();
        test_async_reset();
        test_load_run("zero_ok", 4'd0, 4'd0, 1, 0, 6);
        test_load_run("zero_bad", 4'd3, 4'd0, 1, 0, 6);
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
